// File: rtl/load_store_ctrl_if.sv
// Decode-side and data-memory-side signals of the load/store controller.
// The slave modport is the controller; the master modport drives decode and memory responses.
interface load_store_ctrl_if;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] imm;
  logic [31:0] store_data;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        wb_en;
  logic [1:0]  fault;

  modport master (
    output start, opcode, funct3, rs1_val, imm, store_data, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, load_data, wb_en, fault
  );

  modport slave (
    input  start, opcode, funct3, rs1_val, imm, store_data, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, load_data, wb_en, fault
  );
endinterface

// File: rtl/load_store_ctrl.sv
// Load/store controller: issues one data-memory transfer per decoded load/store,
// checks alignment and funct3, times out a missing ack, and extends load results.
module load_store_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic              clk,
  input logic              reset,
  load_store_ctrl_if.slave bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CW       = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] wait_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   load_data_q;
  logic          wb_en_q;
  logic [1:0]    fault_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;

  logic [31:0]   ea_d;
  logic          is_load_d;
  logic          is_store_d;
  logic          illegal_d;
  logic          misaligned_d;
  logic [1:0]    fault_d;
  logic          accept_d;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(d >> {off, 3'b000});
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Decode the incoming request; illegal funct3 outranks misalignment.
  always_comb begin
    ea_d       = bus.rs1_val + bus.imm;
    is_load_d  = (bus.opcode == OP_LOAD);
    is_store_d = (bus.opcode == OP_STORE);
    illegal_d  = ~f3_legal(is_store_d, bus.funct3);
    case (bus.funct3[1:0])
      2'b01:   misaligned_d = ea_d[0];
      2'b10:   misaligned_d = (ea_d[1:0] != 2'b00);
      default: misaligned_d = 1'b0;
    endcase
    if (illegal_d) begin
      fault_d = 2'b10;
    end else if (misaligned_d) begin
      fault_d = 2'b01;
    end else begin
      fault_d = 2'b00;
    end
    accept_d = (state_q == IDLE) && bus.start && (is_load_d || is_store_d) &&
               (fault_d == 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      load_data_q <= 32'd0;
      wb_en_q     <= 1'b0;
      fault_q     <= 2'b00;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_en_q <= 1'b0;
          fault_q <= 2'b00;
          if (bus.start && (is_load_d || is_store_d)) begin
            if (fault_d != 2'b00) begin
              fault_q <= fault_d;
              state_q <= ERR;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store_d;
              mem_addr_q  <= {ea_d[31:2], 2'b00};
              mem_be_q    <= byte_en(bus.funct3, ea_d[1:0]);
              mem_wdata_q <= is_store_d ? lane_data(bus.funct3, bus.store_data) : 32'd0;
              f3_q        <= bus.funct3;
              off_q       <= ea_d[1:0];
              wait_q      <= '0;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          // An ack in the final allowed cycle still completes the transfer.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            wb_en_q   <= ~mem_we_q;
            if (!mem_we_q) begin
              load_data_q <= extend(f3_q, off_q, bus.mem_rdata);
            end
            state_q <= DONE;
          end else if (wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
            mem_req_q <= 1'b0;
            fault_q   <= 2'b11;
            state_q   <= ERR;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        DONE: begin
          wb_en_q <= 1'b0;
          state_q <= IDLE;
        end
        ERR: begin
          fault_q <= 2'b00;
          state_q <= IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          wb_en_q   <= 1'b0;
          fault_q   <= 2'b00;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.load_data = load_data_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.fault     = fault_q;
  assign bus.stall     = accept_d || (state_q == REQ);
endmodule

// File: tb/tb_load_store_ctrl.sv
// Scoreboard bench for load_store_ctrl: directed transfers push expectations,
// a negedge monitor pops and compares on handshake, write-back and fault events.
module tb_load_store_ctrl;
  localparam int T = 15;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  req_t        req_q[$];
  logic [31:0] wb_q[$];
  logic [1:0]  flt_q[$];

  load_store_ctrl_if bus();

  load_store_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every observable event must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_req && bus.mem_ack) begin
        if (req_q.size() == 0) begin
          chk("unexpected handshake", 32'd1, 32'd0);
        end else begin
          req_t e;
          e = req_q.pop_front();
          chk("mem_we", 32'(bus.mem_we), 32'(e.we));
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_be", 32'(bus.mem_be), 32'(e.be));
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
        end
      end
      if (bus.wb_en) begin
        if (wb_q.size() == 0) chk("unexpected wb_en", 32'd1, 32'd0);
        else chk("load_data", bus.load_data, wb_q.pop_front());
      end
      if (bus.fault != 2'b00) begin
        if (flt_q.size() == 0) chk("unexpected fault", 32'(bus.fault), 32'd0);
        else chk("fault", 32'(bus.fault), 32'(flt_q.pop_front()));
      end
    end
  end

  // ack_at: REQ cycle (1-based) in which mem_ack is given, 0 = never.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [31:0] imm, input logic [31:0] sd, input logic [31:0] rdata,
                        input int ack_at, output int stall_cyc, output int req_cyc);
    logic done;
    stall_cyc = 0;
    req_cyc   = 0;
    done      = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opcode = op; bus.funct3 = f3;
    bus.rs1_val = rs1; bus.imm = imm; bus.store_data = sd;
    @(negedge clk);
    if (bus.stall) stall_cyc++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      bus.mem_ack   = (ack_at == c);
      bus.mem_rdata = (ack_at == c) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (bus.stall) stall_cyc++;
      if (bus.mem_req) begin
        req_cyc++;
      end else begin
        done = 1'b1;
      end
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (done) break;
    end
    chk("transfer bound", 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int s, r;
    bus.start = 1'b0; bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.rs1_val = 32'd0;
    bus.imm = 32'd0; bus.store_data = 32'd0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;

    @(negedge clk);
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst stall", 32'(bus.stall), 32'd0);
    chk("rst load_data", bus.load_data, 32'd0);
    chk("rst wb_en", 32'(bus.wb_en), 32'd0);
    chk("rst fault", 32'(bus.fault), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // LB 0x1000 + -1 = 0xFFF, byte 3 of 0x80FF0000 = 0x80
    req_q.push_back('{1'b0, 32'h0000_0FFC, 4'b1000, 32'd0});
    wb_q.push_back(32'hFFFF_FF80);
    run_op(LD, 3'b000, 32'h1000, 32'hFFFF_FFFF, 32'd0, 32'h80FF_0000, 2, s, r);
    chk("LB stall cycles", 32'(s), 32'd3);
    chk("LB req cycles", 32'(r), 32'd2);

    req_q.push_back('{1'b1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD});
    run_op(ST, 3'b001, 32'h2000, 32'h2, 32'h1234_ABCD, 32'd0, 1, s, r);
    chk("SH stall cycles", 32'(s), 32'd2);

    req_q.push_back('{1'b1, 32'h0000_3000, 4'b0010, 32'h5555_5555});
    run_op(ST, 3'b000, 32'h3000, 32'h1, 32'h0000_0055, 32'd0, 2, s, r);

    req_q.push_back('{1'b1, 32'h0000_4000, 4'b1111, 32'hCAFE_F00D});
    run_op(ST, 3'b010, 32'h3FF0, 32'h10, 32'hCAFE_F00D, 32'd0, 1, s, r);

    req_q.push_back('{1'b0, 32'h0000_0100, 4'b0010, 32'd0});
    wb_q.push_back(32'h0000_0080);
    run_op(LD, 3'b100, 32'h100, 32'h1, 32'd0, 32'h1234_80FF, 1, s, r);

    req_q.push_back('{1'b0, 32'h0000_2000, 4'b1100, 32'd0});
    wb_q.push_back(32'hFFFF_8001);
    run_op(LD, 3'b001, 32'h2000, 32'h2, 32'd0, 32'h8001_1234, 3, s, r);

    // Faults: ack offered in the ERR cycle must be ignored.
    flt_q.push_back(2'b01);
    run_op(LD, 3'b010, 32'h2000, 32'h1, 32'd0, 32'd0, 1, s, r);
    chk("LW misaligned stall", 32'(s), 32'd0);
    chk("LW misaligned req", 32'(r), 32'd0);
    flt_q.push_back(2'b10);
    run_op(LD, 3'b011, 32'h2000, 32'h1, 32'd0, 32'd0, 0, s, r);
    chk("illegal req", 32'(r), 32'd0);
    flt_q.push_back(2'b10);
    run_op(ST, 3'b100, 32'h2000, 32'h0, 32'd0, 32'd0, 0, s, r);
    flt_q.push_back(2'b01);
    run_op(LD, 3'b001, 32'h2000, 32'h3, 32'd0, 32'd0, 0, s, r);

    run_op(7'b0110011, 3'b000, 32'h2000, 32'h0, 32'd0, 32'd0, 1, s, r);
    chk("non-mem stall", 32'(s), 32'd0);
    chk("non-mem req", 32'(r), 32'd0);

    flt_q.push_back(2'b11);
    run_op(LD, 3'b101, 32'h7000, 32'h0, 32'd0, 32'd0, 0, s, r);
    chk("timeout req cycles", 32'(r), 32'(T));
    chk("timeout stall cycles", 32'(s), 32'(T + 1));

    req_q.push_back('{1'b0, 32'h0000_7000, 4'b0011, 32'd0});
    wb_q.push_back(32'h0000_7FFE);
    run_op(LD, 3'b101, 32'h7000, 32'h0, 32'd0, 32'hFFFF_7FFE, T, s, r);
    chk("late ack req cycles", 32'(r), 32'(T));

    // Reset in the middle of REQ drops mem_req without waiting for a clock edge.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opcode = LD; bus.funct3 = 3'b010;
    bus.rs1_val = 32'h5000; bus.imm = 32'h4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("mid-REQ mem_req", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset mem_req", 32'(bus.mem_req), 32'd0);
    chk("async reset stall", 32'(bus.stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    req_q.push_back('{1'b0, 32'h0000_6008, 4'b1111, 32'd0});
    wb_q.push_back(32'h1122_3344);
    run_op(LD, 3'b010, 32'h6000, 32'h8, 32'd0, 32'h1122_3344, 3, s, r);

    chk("req queue drained", 32'(req_q.size()), 32'd0);
    chk("wb queue drained", 32'(wb_q.size()), 32'd0);
    chk("fault queue drained", 32'(flt_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum cycles in REQ without mem_ack before a timeout fault is raised.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  decode pulse: the current instruction requests a memory operation.
REQ-005 opcode  input  7  instruction[6:0]; 0000011 = load, 0100011 = store.
REQ-006 funct3  input  3  instruction[14:12]; selects access size and signedness.
REQ-007 rs1_val  input  32  base register value.
REQ-008 imm  input  32  sign-extended immediate from the immediate generator.
REQ-009 store_data  input  32  rs2 value for stores.
REQ-010 mem_ack  input  1  data memory completion strobe.
REQ-011 mem_rdata  input  32  data memory read word, valid with mem_ack.
REQ-012 mem_req  output  1  memory request, held high until acknowledged.
REQ-013 mem_we  output  1  1 = write, 0 = read.
REQ-014 mem_addr  output  32  word-aligned address: effective address with bits [1:0] = 00.
REQ-015 mem_be  output  4  byte enables.
REQ-016 mem_wdata  output  32  lane-replicated write data.
REQ-017 stall  output  1  holds the PC and pipeline while a transfer is in flight.
REQ-018 load_data  output  32  extended load result.
REQ-019 wb_en  output  1  one-cycle register-file write strobe for loads.
REQ-020 fault  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout; valid for one cycle.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, REQ, DONE and ERR.
REQ-022 The effective address SHALL be rs1_val + imm, modulo 2^32, with carry-out discarded.
REQ-023 IDLE: start is ignored when opcode is neither load nor store.
REQ-024 IDLE: a legal start SHALL latch the address, mem_we, mem_be, mem_wdata, funct3 and byte offset, then move to REQ on the next edge.
REQ-025 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-026 An illegal funct3 SHALL move IDLE to ERR with fault = 10.
REQ-027 A misaligned access SHALL move IDLE to ERR with fault = 01; misaligned means halfword with addr[0] = 1, or word with addr[1:0] != 00.
REQ-028 Illegal funct3 SHALL take priority over misalignment.
REQ-029 Byte enables: byte access = 1 << addr[1:0]; halfword = 0011 when addr[1] = 0, else 1100; word = 1111.
REQ-030 Write data: SB = store_data[7:0] replicated ×4; SH = store_data[15:0] replicated ×2; SW = store_data.
REQ-031 REQ: mem_req SHALL be 1 and the latched outputs SHALL stay stable until mem_ack.
REQ-032 REQ: on mem_ack the block SHALL capture mem_rdata and move to DONE.
REQ-033 REQ: a wait counter SHALL clear on entry and increment each cycle without mem_ack.
REQ-034 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL move to ERR with fault = 11; mem_ack in that same cycle takes priority (move to DONE).
REQ-035 DONE: for one cycle, wb_en = 1 for loads and 0 for stores, and load_data is valid; the next state is IDLE.
REQ-036 Load extension: the selected byte or halfword (by offset) SHALL be sign-extended for LB/LH and zero-extended for LBU/LHU; LW passes the word through.
REQ-037 ERR: for one cycle, fault holds the code, wb_en = 0 and mem_req = 0; the next state is IDLE.
REQ-038 stall = 1 in the cycle a legal start is accepted and throughout REQ; stall = 0 in IDLE otherwise, in DONE and in ERR.
REQ-039 start SHALL be ignored outside IDLE.
REQ-040 mem_ack SHALL be ignored outside REQ.
REQ-041 mem_req SHALL be 0 outside REQ.

Reset
REQ-042 Asserting reset SHALL force IDLE asynchronously.
REQ-043 On reset, all outputs SHALL be 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, load_data, wb_en and fault.
REQ-044 On reset, the wait counter and all latched fields SHALL clear.
REQ-045 Reset during REQ SHALL drop mem_req immediately; no wb_en or fault follows.

Verification
REQ-046 LB, rs1_val = 0x1000, imm = 0xFFFFFFFF, mem_rdata = 0x80FF0000, ack on the 2nd REQ cycle -> mem_addr = 0x00000FFC, mem_be = 1000, load_data = 0xFFFFFF80, wb_en = 1 for 1 cycle, stall = 1 for 3 cycles.
REQ-047 SH, effective address 0x2002, store_data = 0x1234ABCD -> mem_be = 1100, mem_wdata = 0xABCDABCD, mem_we = 1, wb_en = 0 in DONE.
REQ-048 LW at effective address 0x2001 -> ERR, fault = 01 for 1 cycle, mem_req never asserted.
REQ-049 Load with funct3 = 011 at effective address 0x2001 -> fault = 10.
REQ-050 LHU, mem_ack never asserted -> mem_req high for TIMEOUT_CYCLES cycles, then fault = 11 and return to IDLE; a variant with ack in the final cycle -> DONE.
REQ-051 Reset pulse in mid-REQ, then start with a new LW -> mem_req falls asynchronously; the new transfer completes normally with no stale fault.
